fir_mac_sequencer: RTL and testbench

//   Control FSM for the shared multiply-accumulate datapath of the FIR filter.
//   On each input sample strobe it does the following:
//   - writes the sample into a circular delay-line RAM;
//   - clears the 2N-bit accumulator register;
//   - steps TAPS coefficient/sample address pairs through the multiplier;
//   - loads the finished 2N-bit sum into the output register.
//   It sits between the sample source and the RAM/ROM/multiplier/accumulator.

---
 rtl/fir_mac_sequencer.sv | 102 ++++++++++
 tb/tb_fir_mac_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_sequencer.sv
// Control FSM for the shared FIR multiply-accumulate datapath.
// Sequences delay-line write, accumulator clear, TAPS MAC steps and output load.
module fir_mac_sequencer #(
    parameter int TAPS   = 5,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_valid,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] coef_addr,
    output logic              acc_clr,
    output logic              acc_en,
    output logic              out_load,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        MAC,
        LOAD
    } state_t;

    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(TAPS - 1);
    localparam logic [ADDR_W-1:0] TAPS_A = ADDR_W'(TAPS);

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] wr_ptr_nx;
    logic [ADDR_W-1:0] k;
    logic [ADDR_W-1:0] k_nx;
    logic              ovr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            wr_ptr <= '0;
            k      <= '0;
            ovr_q  <= 1'b0;
        end else begin
            state  <= state_nx;
            wr_ptr <= wr_ptr_nx;
            k      <= k_nx;
            ovr_q  <= sample_valid && (state != IDLE);
        end
    end

    always_comb begin
        state_nx  = state;
        wr_ptr_nx = wr_ptr;
        k_nx      = k;
        wr_en     = 1'b0;
        acc_clr   = 1'b0;
        acc_en    = 1'b0;
        out_load  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        wr_addr   = wr_ptr;
        rd_addr   = wr_ptr;
        coef_addr = '0;
        unique case (state)
            IDLE: begin
                if (sample_valid) state_nx = WRITE;
            end
            WRITE: begin
                wr_en    = 1'b1;
                acc_clr  = 1'b1;
                busy     = 1'b1;
                k_nx     = '0;
                state_nx = MAC;
            end
            MAC: begin
                acc_en    = 1'b1;
                busy      = 1'b1;
                coef_addr = k;
                // Circular read of x[n-k] without a modulo operator
                if (wr_ptr >= k) rd_addr = wr_ptr - k;
                else             rd_addr = wr_ptr + TAPS_A - k;
                k_nx = k + 1'b1;
                if (k == LAST) state_nx = LOAD;
            end
            LOAD: begin
                out_load = 1'b1;
                done     = 1'b1;
                busy     = 1'b1;
                if (wr_ptr == LAST) wr_ptr_nx = '0;
                else                wr_ptr_nx = wr_ptr + 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign overrun = ovr_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Testbench for fir_mac_sequencer: emulated RAM/ROM/accumulator datapath
// checked against a direct-form FIR sum over the accepted-sample history.
module tb_fir_mac_sequencer;

    localparam int TAPS = 5;
    localparam int AW   = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          sample_valid;
    logic [7:0]    x_in;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] coef_addr;
    logic          acc_clr;
    logic          acc_en;
    logic          out_load;
    logic          busy;
    logic          done;
    logic          overrun;

    int total = 0;
    int bad   = 0;

    int ram [8];
    int acc;
    int out_reg;
    int done_cnt = 0;
    int ovr_cnt  = 0;

    int hist[$];
    int n_acc = 0;
    int sid   = 0;

    fir_mac_sequencer #(.TAPS(TAPS), .ADDR_W(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .rd_addr      (rd_addr),
        .coef_addr    (coef_addr),
        .acc_clr      (acc_clr),
        .acc_en       (acc_en),
        .out_load     (out_load),
        .busy         (busy),
        .done         (done),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    // Datapath emulation: h[k] = k+1, RAM holds raw samples
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            acc     = 0;
            out_reg = 0;
            for (int i = 0; i < 8; i++) ram[i] = 0;
        end else begin
            if (wr_en)    ram[wr_addr] = int'(x_in);
            if (acc_clr)  acc = 0;
            if (acc_en)   acc = acc + ram[rd_addr] * (int'(coef_addr) + 1);
            if (out_load) out_reg = acc;
        end
    end

    always @(negedge clk) begin
        if (done)    done_cnt++;
        if (overrun) ovr_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wr_en"}, 32'(wr_en), 0);
        chk({tag, "_acc_clr"}, 32'(acc_clr), 0);
        chk({tag, "_acc_en"}, 32'(acc_en), 0);
        chk({tag, "_out_load"}, 32'(out_load), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_overrun"}, 32'(overrun), 0);
        chk({tag, "_wr_addr"}, 32'(wr_addr), 0);
        chk({tag, "_rd_addr"}, 32'(rd_addr), 0);
        chk({tag, "_coef_addr"}, 32'(coef_addr), 0);
    endtask

    function automatic int fir_sum();
        int s = 0;
        for (int k = 0; k < TAPS && k < hist.size(); k++)
            s += (k + 1) * hist[k];
        return s;
    endfunction

    // Entered and left at a falling edge with the sequencer idle.
    // ovr_at: cycle whose closing edge sees a spurious strobe (0 = none).
    // abort_at: cycle after whose checks reset is asserted (0 = none).
    task automatic run_sample(input int x, input int ovr_at,
                              input int abort_at);
        int    p  = n_acc % TAPS;
        int    pn = (n_acc + 1) % TAPS;
        int    y;
        int    m;
        int    ra;
        string t;
        sid++;
        hist.push_front(x);
        y = fir_sum();
        sample_valid = 1'b1;
        x_in = 8'(x);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            sample_valid = (c == ovr_at);
            t = $sformatf("s%0d_c%0d", sid, c);
            m = c - 2;
            ra = (c >= 2 && c <= 6) ? (p - m + TAPS) % TAPS
                                    : ((c == 8) ? pn : p);
            chk({t, "_wr_en"}, 32'(wr_en), 32'(c == 1));
            chk({t, "_acc_clr"}, 32'(acc_clr), 32'(c == 1));
            chk({t, "_acc_en"}, 32'(acc_en), 32'(c >= 2 && c <= 6));
            chk({t, "_out_load"}, 32'(out_load), 32'(c == 7));
            chk({t, "_done"}, 32'(done), 32'(c == 7));
            chk({t, "_busy"}, 32'(busy), 32'(c <= 7));
            chk({t, "_overrun"}, 32'(overrun),
                32'(ovr_at > 0 && c == ovr_at + 1));
            chk({t, "_rd_addr"}, 32'(rd_addr), 32'(ra));
            chk({t, "_coef_addr"}, 32'(coef_addr),
                32'((c >= 2 && c <= 6) ? m : 0));
            if (c == 1) chk({t, "_wr_addr"}, 32'(wr_addr), 32'(p));
            if (c == 8) chk({t, "_sum"}, 32'(out_reg), 32'(y));
            if (c == abort_at) begin
                reset = 1'b1;
                #1;
                chk_zero({t, "_async_rst"});
                @(negedge clk);
                chk_zero({t, "_rst_hold"});
                reset = 1'b0;
                n_acc = 0;
                hist.delete();
                return;
            end
        end
        n_acc++;
    endtask

    initial begin
        int d0;
        int o0;
        reset = 1'b1;
        sample_valid = 1'b0;
        x_in = '0;
        #1;
        chk_zero("reset_async");
        @(negedge clk);
        @(negedge clk);
        chk_zero("reset_held");
        reset = 1'b0;
        @(negedge clk);
        chk_zero("idle");

        run_sample(1, 0, 0);
        run_sample(2, 0, 0);
        chk("t2_sum_four", 32'(out_reg), 32'd4);

        run_sample(3, 0, 0);
        run_sample(4, 0, 0);
        run_sample(5, 0, 0);
        run_sample(6, 0, 0);

        run_sample(int'($urandom_range(0, 255)), 3, 0);
        run_sample(int'($urandom_range(0, 255)), 5, 0);

        run_sample(int'($urandom_range(0, 255)), 0, 4);
        run_sample(int'($urandom_range(0, 255)), 0, 0);

        d0 = done_cnt;
        o0 = ovr_cnt;
        for (int i = 0; i < 20; i++)
            run_sample(int'($urandom_range(0, 255)), 0, 0);
        #1;
        chk("t6_done_count", 32'(done_cnt - d0), 32'd20);
        chk("t6_no_overrun", 32'(ovr_cnt - o0), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
